// File: rtl/led_bank_arbiter_pkg.sv
// Shared types and helpers for the LED bank arbiter.
// State encoding, requester count and round-robin search.
package led_bank_arbiter_pkg;

   localparam int NREQ = 3;

   typedef enum logic {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   // First set bit of req found after index from, wrapping; from itself is last.
   function automatic logic [1:0] rr_next(
      input logic [NREQ-1:0] req,
      input logic [1:0]      from
   );
      logic [1:0] idx;
      rr_next = from;
      for (int k = NREQ; k >= 1; k--) begin
         idx = 2'((int'(from) + k) % NREQ);
         if (req[idx]) rr_next = idx;
      end
   endfunction

   function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
      onehot = NREQ'(1) << idx;
   endfunction

endpackage

// File: rtl/led_bank_arbiter_tick.sv
// Free-running prescaler producing a one-cycle hold tick.
// Never re-phased by arbitration activity.
module tick_gen #(
   parameter int TICK_DIV = 250000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/led_bank_arbiter.sv
// Round-robin owner of a 4-LED bank shared by three requesters.
// Owner holds for HOLD_TICKS ticks before contenders may take over.
module led_bank_arbiter
   import led_bank_arbiter_pkg::*;
#(
   parameter int TICK_DIV   = 250000,
   parameter int HOLD_TICKS = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req,
   input  logic [3:0]      pat0,
   input  logic [3:0]      pat1,
   input  logic [3:0]      pat2,
   output logic [NREQ-1:0] grant,
   output logic            busy,
   output logic            led1,
   output logic            led2,
   output logic            led3,
   output logic            led4
);

   localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

   state_t          state;
   logic [1:0]      owner;
   logic [1:0]      last;
   logic [HW-1:0]   hold_cnt;
   logic [3:0]      leds;
   logic            tick;
   logic            expired;
   logic [NREQ-1:0] others;
   logic [1:0]      pick;
   logic [1:0]      nxt;
   logic [3:0]      pats [NREQ];

   tick_gen #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   assign pats[0] = pat0;
   assign pats[1] = pat1;
   assign pats[2] = pat2;

   assign {led4, led3, led2, led1} = leds;

   // Registered compare: the tick that saturates the count cannot switch.
   assign expired = (hold_cnt == HW'(HOLD_TICKS));
   assign others  = req & ~grant;
   assign pick    = rr_next(req, last);
   assign nxt     = rr_next(others, owner);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         owner    <= 2'd0;
         last     <= 2'd2;
         grant    <= '0;
         busy     <= 1'b0;
         hold_cnt <= '0;
         leds     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|req) begin
                  state    <= OWN;
                  owner    <= pick;
                  last     <= pick;
                  grant    <= onehot(pick);
                  busy     <= 1'b1;
                  hold_cnt <= '0;
                  leds     <= pats[pick];
               end
            end
            OWN: begin
               if (!req[owner]) begin
                  state    <= IDLE;
                  grant    <= '0;
                  busy     <= 1'b0;
                  hold_cnt <= '0;
                  leds     <= '0;
               end else if (expired && (|others)) begin
                  owner    <= nxt;
                  last     <= nxt;
                  grant    <= onehot(nxt);
                  hold_cnt <= '0;
                  leds     <= pats[nxt];
               end else begin
                  leds <= pats[owner];
                  if (tick && !expired) begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               grant <= '0;
               busy  <= 1'b0;
               leds  <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/led_bank_arbiter.md
LED_BANK_ARBITER -- requirements
Module: led_bank_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  TICK_DIV  250000  clk cycles per hold tick
  HOLD_TICKS  4  ticks the owner holds the LED bank before a contending requester may take it
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock; all logic on posedge
  rst  in  1  synchronous, active-high reset
  req  in  3  req[i]=1: requester i wants the LED bank
  pat0  in  4  requester 0 pattern, bit0..bit3 -> led1..led4
  pat1  in  4  requester 1 pattern
  pat2  in  4  requester 2 pattern
  grant  out  3  one-hot owner, 3'b000 when idle
  busy  out  1  1 while in OWN
  led1..led4  out  1 each  registered LED drives
REQ-003 Reset SHALL be synchronous and active-high, on port rst, sampled on posedge clk; there SHALL be exactly one clock, clk.

Function
REQ-004 The prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; tick SHALL be 1 for exactly the cycle the count equals TICK_DIV-1.
REQ-005 The prescaler SHALL run freely from reset and SHALL NOT re-phase on grant changes.
REQ-006 The FSM SHALL have two states: IDLE (grant=0, busy=0) and OWN (grant one-hot, busy=1).
REQ-007 In IDLE with req!=0, the block SHALL grant round-robin, starting the search at (last+1) mod 3, where last is the previous owner index. It SHALL enter OWN with grant registered on the next edge and hold_cnt=0.
REQ-008 In IDLE with req=0, the block SHALL remain in IDLE with outputs unchanged at zero.
REQ-009 In OWN, hold_cnt SHALL increment on each tick and saturate at HOLD_TICKS.
REQ-010 In OWN, if req[owner]=0, the block SHALL go to IDLE on the next edge: grant=0, busy=0, LEDs=0. This SHALL take priority over every other OWN condition, including a tick in the same cycle.
REQ-011 In OWN with req[owner]=1, hold_cnt==HOLD_TICKS and another req bit set, the grant SHALL move directly, with no IDLE cycle, to the next requester in round-robin order, and hold_cnt SHALL become 0.
REQ-012 In OWN with hold expired and no other requester, the owner SHALL keep the bank indefinitely.
REQ-013 A tick arriving in the same cycle hold_cnt reaches HOLD_TICKS SHALL NOT trigger the switch; the expiry SHALL be evaluated from the next cycle on.
REQ-014 led1..led4 SHALL equal the owner's pattern bits sampled one cycle earlier, tracking live pattern changes with 1-cycle latency; in IDLE they SHALL be 0.
REQ-015 grant SHALL never have more than one bit set.
REQ-016 When grant changes, the LEDs SHALL show the new owner's pattern on the same edge on which grant updates.

Reset
REQ-017 While rst=1 on an edge: state=IDLE, grant=0, busy=0, led1..led4=0, prescaler=0, hold_cnt=0, last=2 (requester 0 has first priority).
REQ-018 rst asserted mid-ownership SHALL abort it on that edge with no residual LED output.

Structure
REQ-019 A shared package SHALL hold the FSM state encoding (IDLE, OWN) and the requester count constant (3).
REQ-020 The prescaler SHALL be a separate sub-module, tick_gen, parameterised by TICK_DIV, with ports clk, rst and tick.
REQ-021 The arbiter FSM, hold counter and LED register SHALL live in led_bank_arbiter; the expected size is 150-250 lines total.

Verification
REQ-022 The bench SHALL use TICK_DIV=4 and HOLD_TICKS=2 and cover:
  - Reset, then req=3'b000 for 20 cycles -> grant=0, busy=0, LEDs=0 throughout.
  - req=3'b001, pat0=4'b1010 -> next edge grant=001, busy=1, {led4..led1}=1010; pat0 changed to 0101 -> LEDs 0101 one cycle later.
  - req=3'b111 from reset -> grant 001; after the 2-tick hold plus 1 cycle -> 010, then 100, then 001 (rotation, no IDLE gap).
  - Owner req0 drops in the same cycle as a tick while req1 is pending -> IDLE for one cycle (grant=0, LEDs=0), then grant=010.
  - Single requester req=3'b100 held for 10 ticks -> grant stays 100.
  - rst pulsed for 1 cycle while grant=010 -> grant=0 and LEDs=0 on that edge; with req=3'b011 afterwards -> grant=001 first.
